led7seg_scan: RTL and testbench
===============================

# led7seg_scan

Multiplexed scan driver for the 3-digit 7-segment display on the sample board. It sits directly downstream of the 24-bit `led7seg_export` PIO of the Nios II core and turns that static register image into time-multiplexed segment and common drives. The driver adds ghost-free blanking between digits, 16-level PWM brightness, and tear-free per-frame latching of the input image.

## Interface
Parameters:
- `STEP_CYCLES`, 16: clocks per PWM step; must be a power of two, ≥2.
- `BLANK_CYCLES`, 8: dead-time clocks at the start of each digit slot, ≥1.
- `SEG_ACTIVE_LOW`, 1: 1 = segment lit by driving 0.
- `COM_ACTIVE_LOW`, 1: 1 = digit enabled by driving 0.

Ports:
- `clk`, in, 1: the single clock domain.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `led7seg_data`, in, 24: digit d = bits [8d+7:8d]; bit 7 = dp, bits 6:0 = g..a; 1 = lit.
- `brightness`, in, 4: PWM level 0..15; lit steps per slot = brightness+1.
- `disp_enable`, in, 1: 0 blanks the display at the next frame.
- `seg_out`, out, 8: segment drive, polarity per `SEG_ACTIVE_LOW`.
- `com_out`, out, 3: digit commons, polarity per `COM_ACTIVE_LOW`.
- `frame_tick`, out, 1: one-clock pulse at each frame start.

## Operation
- Slot length is SLOT = BLANK_CYCLES + 16·STEP_CYCLES. With defaults that is 264 clocks; a frame is 3 slots (792 clocks).
- Counters:
  - `slot_cnt` runs 0..SLOT-1, then wraps.
  - `digit` runs 0→1→2→0 and advances when `slot_cnt` wraps.
- Frame start is `digit`=0 and `slot_cnt`=0. In that cycle `led7seg_data`, `brightness` and `disp_enable` are captured into shadow registers. Changes at other times have no effect until the next frame start.
- Per-cycle lit decision (combinational from counters and shadows):
  - Blank when `slot_cnt` < BLANK_CYCLES.
  - Otherwise step = (`slot_cnt` − BLANK_CYCLES) / STEP_CYCLES, range 0..15.
  - lit = shadow_enable AND (step ≤ shadow_brightness).
- When lit: `com_out` asserts only bit `digit`, and `seg_out` = shadow byte of `digit`.
- When not lit: all commons and all segments are inactive. Segments never carry a digit's data while its common is deasserted.
- Polarity: the physical level is the logical value XOR-inverted per parameter, applied at the output registers.
- The first frame after reset shows the data captured in the first cycle after `reset_n` deasserts.

## Timing
- All outputs are registered. Each output reflects the counter state of the previous cycle (latency 1 clock).
- Reset values, asynchronous, with defaults:
  - `seg_out` = 8'hFF, `com_out` = 3'b111 (inactive levels per parameters).
  - `frame_tick` = 0.
  - `slot_cnt` = 0, `digit` = 0, shadows = 0.
- `frame_tick` is high for exactly one clock, the clock after the frame-start capture cycle. It repeats every 3·SLOT clocks.
- Per slot with defaults:
  - com active for (brightness+1)·16 clocks, contiguous, starting 8 clocks after the slot boundary.
  - Then inactive until the slot ends.
  - brightness 15 gives 256 active and 8 dead clocks.
- Reset asserted mid-frame forces the reset values in the same cycle, regardless of clock. After release, scanning restarts at digit 0, slot cycle 0.
- A `disp_enable` falling mid-frame takes effect at the next frame start, not immediately.

## Test plan
- Reset: hold `reset_n`=0 for 5 clocks, then release. Required:
  - `com_out`=3'b111, `seg_out`=8'hFF during reset.
  - First `frame_tick` one clock after release, then every 792 clocks.
- Full brightness: `led7seg_data`=24'h06_5B_3F, `brightness`=15, `disp_enable`=1. Required:
  - Each com goes low for 256 clocks, then is high for 8 clocks.
  - `seg_out`=~8'h3F on com0, ~8'h5B on com1, ~8'h06 on com2.
  - Never two commons low at once.
- Dimming: `brightness`=0, then `brightness`=7. Required: com0 low 16 clocks per slot (brightness 0), then 128 clocks per slot (brightness 7). Each change applies only after the next `frame_tick`.
- Tearing: change `led7seg_data` while digit 1 is active. Required: digits 1 and 2 keep the old values for the rest of that frame; the new values appear from the next frame.
- Disable: `disp_enable`=0. Required: from the next frame, `com_out`=3'b111 and `seg_out`=8'hFF continuously, while `frame_tick` continues.
- Async reset mid-slot: pulse `reset_n` low for a half clock during digit 2 active. Required: outputs go inactive immediately; after release, scanning restarts at digit 0.

Source files
------------

// File: rtl/led7seg_scan.sv
// led7seg_scan: multiplexed 3-digit 7-segment scan driver with inter-digit blanking,
// 16-level PWM brightness and per-frame latching of the display image.
module led7seg_scan #(
    parameter int STEP_CYCLES    = 16,
    parameter int BLANK_CYCLES   = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit COM_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] led7seg_data,
    input  logic [3:0]  brightness,
    input  logic        disp_enable,
    output logic [7:0]  seg_out,
    output logic [2:0]  com_out,
    output logic        frame_tick
);
    localparam int SLOT = BLANK_CYCLES + 16 * STEP_CYCLES;
    localparam int CW = $clog2(SLOT);
    localparam int SW = $clog2(STEP_CYCLES);
    localparam logic [7:0] SEG_INV = {8{SEG_ACTIVE_LOW}};
    localparam logic [2:0] COM_INV = {3{COM_ACTIVE_LOW}};

    logic [CW-1:0] slot_q, slot_d, offset;
    logic [1:0]    digit_q, digit_d;
    logic [23:0]   data_q;
    logic [3:0]    bright_q, step;
    logic          en_q, frame_start, slot_end, lit;
    logic [7:0]    seg_d;
    logic [2:0]    com_d;

    always_comb begin
        frame_start = (digit_q == 2'd0) && (slot_q == '0);
        slot_end    = (slot_q == CW'(SLOT - 1));
        slot_d      = slot_end ? '0 : slot_q + CW'(1);
        digit_d     = !slot_end ? digit_q : (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
        // offset wraps during the blank window; step is only used once past it
        offset      = slot_q - CW'(BLANK_CYCLES);
        step        = 4'(offset >> SW);
        lit         = en_q && (slot_q >= CW'(BLANK_CYCLES)) && (step <= bright_q);
        seg_d       = !lit ? 8'h00 :
                      (digit_q == 2'd0) ? data_q[7:0] :
                      (digit_q == 2'd1) ? data_q[15:8] : data_q[23:16];
        com_d       = lit ? (3'b001 << digit_q) : 3'b000;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q     <= '0;
            digit_q    <= 2'd0;
            data_q     <= '0;
            bright_q   <= '0;
            en_q       <= 1'b0;
            seg_out    <= SEG_INV;
            com_out    <= COM_INV;
            frame_tick <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            digit_q    <= digit_d;
            if (frame_start) begin
                data_q   <= led7seg_data;
                bright_q <= brightness;
                en_q     <= disp_enable;
            end
            seg_out    <= seg_d ^ SEG_INV;
            com_out    <= com_d ^ COM_INV;
            frame_tick <= frame_start;
        end
    end
endmodule

// File: tb/tb_led7seg_scan.sv
// tb_led7seg_scan: table vectors, corner sequences and random stimulus checked against
// a frame/slot arithmetic model of the scan driver.
module tb_led7seg_scan;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] led7seg_data = '0;
    logic [3:0]  brightness = '0;
    logic        disp_enable = 1'b0;
    logic [7:0]  seg_out;
    logic [2:0]  com_out;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;
    int k = 0;
    logic [23:0] sh_data = '0;
    logic [3:0]  sh_b = '0;
    logic        sh_en = 1'b0;

    typedef struct {
        logic [23:0] data;
        logic [3:0]  bright;
        logic        en;
        int          on_cnt;
        logic [7:0]  seg [3];
    } vec_t;
    vec_t vecs [4];

    always #5 clk = ~clk;

    led7seg_scan dut (
        .clk(clk), .reset_n(reset_n), .led7seg_data(led7seg_data),
        .brightness(brightness), .disp_enable(disp_enable),
        .seg_out(seg_out), .com_out(com_out), .frame_tick(frame_tick)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at k=%0d: got %h expected %h", n, k, a, e);
        end
    endtask

    // Model: k counts scan cycles since reset release; frame/slot positions by division.
    task automatic tick();
        int r, d, s;
        logic lit;
        logic [2:0] ec;
        logic [7:0] es;
        @(posedge clk);
        if (k % 792 == 0) begin
            sh_data = led7seg_data;
            sh_b = brightness;
            sh_en = disp_enable;
        end
        r = k % 792;
        d = r / 264;
        s = r % 264;
        lit = sh_en && s >= 8 && ((s - 8) / 16) <= int'(sh_b);
        ec = lit ? ~(3'b001 << d) : 3'b111;
        es = lit ? ~sh_data[8*d +: 8] : 8'hFF;
        k++;
        #1;
        chk("com", com_out, ec);
        chk("seg", seg_out, es);
        chk("tick", frame_tick, r == 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("rst_com", com_out, 3'b111);
            chk("rst_seg", seg_out, 8'hFF);
            chk("rst_tick", frame_tick, 1'b0);
        end
        reset_n = 1'b1;
        k = 0;
    endtask

    task automatic to_phase(input int p);
        while (k % 792 != p) tick();
    endtask

    initial begin
        int on [3];
        int ticks;
        logic [7:0] segv [3];
        logic [7:0] last;
        vecs[0] = '{24'h065B3F, 4'd15, 1'b1, 256, '{8'hC0, 8'hA4, 8'hF9}};
        vecs[1] = '{24'h065B3F, 4'd0,  1'b1, 16,  '{8'hC0, 8'hA4, 8'hF9}};
        vecs[2] = '{24'h065B3F, 4'd7,  1'b1, 128, '{8'hC0, 8'hA4, 8'hF9}};
        vecs[3] = '{24'h065B3F, 4'd15, 1'b0, 0,   '{8'hFF, 8'hFF, 8'hFF}};
        led7seg_data = 24'h065B3F;
        brightness = 4'd15;
        disp_enable = 1'b1;
        do_reset();

        for (int i = 0; i < 4; i++) begin
            led7seg_data = vecs[i].data;
            brightness = vecs[i].bright;
            disp_enable = vecs[i].en;
            to_phase(0);
            ticks = 0;
            for (int j = 0; j < 3; j++) begin on[j] = 0; segv[j] = 8'hFF; end
            repeat (792) begin
                tick();
                for (int j = 0; j < 3; j++)
                    if (com_out[j] == 1'b0) begin on[j]++; segv[j] = seg_out; end
                if (frame_tick) ticks++;
            end
            for (int j = 0; j < 3; j++) begin
                chk("on_cnt", on[j], vecs[i].on_cnt);
                chk("seg_digit", segv[j], vecs[i].seg[j]);
            end
            chk("ticks_per_frame", ticks, 1);
        end

        // tearing: new image written while digit 1 is lit
        led7seg_data = 24'h065B3F;
        brightness = 4'd15;
        disp_enable = 1'b1;
        to_phase(0);
        to_phase(264 + 20);
        led7seg_data = 24'h7F664F;
        last = 8'h00;
        while (k % 792 != 0) begin
            tick();
            if (com_out == 3'b011) last = seg_out;
        end
        chk("tear_old_d2", last, 8'hF9);
        last = 8'h00;
        repeat (792) begin
            tick();
            if (com_out == 3'b101) last = seg_out;
        end
        chk("tear_new_d1", last, 8'h99);

        // async reset pulse while digit 2 is lit
        to_phase(528 + 50);
        reset_n = 1'b0;
        #2;
        chk("async_com", com_out, 3'b111);
        chk("async_seg", seg_out, 8'hFF);
        chk("async_tick", frame_tick, 1'b0);
        #3;
        reset_n = 1'b1;
        k = 0;
        repeat (10) tick();
        chk("restart_d0", com_out, 3'b110);

        // random images, levels and mid-frame changes
        for (int i = 0; i < 8; i++) begin
            led7seg_data = 24'($urandom);
            brightness = 4'($urandom_range(0, 15));
            disp_enable = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(300, 1200)) begin
                tick();
                if ($urandom_range(0, 49) == 0) begin
                    led7seg_data = 24'($urandom);
                    brightness = 4'($urandom_range(0, 15));
                    disp_enable = ($urandom_range(0, 3) != 0);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
